// File: rtl/gray_binary_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gray_binary_seq_if
//  Description : Handshake bundle for gray_binary_seq. The input side carries
//                a Gray word (in_valid/in_ready/gray). The output side carries
//                the decoded binary word (out_valid/out_ready/bin).
//                step_err is present only when GRAY_BINARY_STEP_CHECK_EN is
//                defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface gray_binary_seq_if #(
   parameter int N = 4
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] gray;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] bin;
`ifdef GRAY_BINARY_STEP_CHECK_EN
   logic         step_err;
`endif

`ifdef GRAY_BINARY_STEP_CHECK_EN
   // Producer/consumer side: drives words in and takes results out
   modport master (
      output in_valid, gray, out_ready,
      input  in_ready, out_valid, bin, step_err
   );
   // Decoder side
   modport slave (
      input  in_valid, gray, out_ready,
      output in_ready, out_valid, bin, step_err
   );
`else
   // Producer/consumer side: drives words in and takes results out
   modport master (
      output in_valid, gray, out_ready,
      input  in_ready, out_valid, bin
   );
   // Decoder side
   modport slave (
      input  in_valid, gray, out_ready,
      output in_ready, out_valid, bin
   );
`endif
endinterface
`default_nettype wire

// File: rtl/gray_binary_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gray_binary_seq
//  Description : Sequential Gray-to-binary decoder. A Gray word is accepted
//                over a valid/ready handshake and resolved MSB-first, one bit
//                per clock, using bin[i] = bin[i+1] ^ gray[i]. The result is
//                held until downstream takes it. Latency from acceptance to
//                out_valid is N-1 cycles.
//                Optional macro GRAY_BINARY_STEP_CHECK_EN adds step_err. That
//                flag is raised when an accepted word differs from the
//                previously accepted word in more than one bit.
//  Revision    : 1.0  initial release
// ============================================================================
module gray_binary_seq #(
   parameter int N = 4            // word width, N >= 2
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   gray_binary_seq_if.slave bus
);

   // Bit index register is wide enough to hold N-2. N-1 still fits, which
   // covers the idx+1 read of the already-resolved neighbour bit.
   localparam int              c_idx_w     = $clog2(N);
   localparam logic [c_idx_w-1:0] c_idx_start = c_idx_w'(N - 2);
   localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [N-1:0]         r_gray;       // captured Gray word
   logic [N-1:0]         r_bin;        // binary result, resolved MSB-first
   logic [c_idx_w-1:0]   r_idx;        // next bit to resolve
   logic                 r_out_valid;

   logic                 w_accept;
   logic                 w_next_bit;

   // Words are only taken in IDLE. BUSY and DONE ignore in_valid.
   assign w_accept   = bus.in_valid && (r_state == ST_IDLE);

   // Each binary bit is the bit above it XORed with the Gray bit at its own
   // position. The bit above is always resolved already.
   assign w_next_bit = r_bin[r_idx + c_idx_one] ^ r_gray[r_idx];

   // Decode FSM: capture on accept, resolve one bit per edge, hold until taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_gray      <= '0;
         r_bin       <= '0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  // The MSB of a Gray word equals the binary MSB. Lower bits
                  // start clean so no stale result bits linger in bin.
                  r_gray  <= bus.gray;
                  r_bin   <= {bus.gray[N-1], {(N-1){1'b0}}};
                  r_idx   <= c_idx_start;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               r_bin[r_idx] <= w_next_bit;
               if (r_idx == '0) begin
                  // Last bit resolved on this edge. idx stays at 0 and never
                  // wraps.
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_idx <= r_idx - c_idx_one;
               end
            end
            ST_DONE: begin
               // The result handshake only returns to IDLE. A new word is
               // taken no earlier than the following edge.
               if (bus.out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.bin       = r_bin;

`ifdef GRAY_BINARY_STEP_CHECK_EN
   logic [N-1:0] r_prev;          // last accepted Gray word
   logic         r_seen;          // at least one word accepted since reset
   logic         r_step_err;
   logic [N-1:0] w_diff;
   logic         w_multi;

   assign w_diff  = bus.gray ^ r_prev;
   // More than one differing bit exactly when clearing the lowest set bit
   // still leaves a bit set.
   assign w_multi = |(w_diff & (w_diff - {{(N-1){1'b0}}, 1'b1}));

   // Step check: compare each accepted word with its predecessor
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev     <= '0;
         r_seen     <= 1'b0;
         r_step_err <= 1'b0;
      end else if (w_accept) begin
         r_step_err <= r_seen & w_multi;
         r_prev     <= bus.gray;
         r_seen     <= 1'b1;
      end
   end

   assign bus.step_err = r_step_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_binary_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_gray_binary_seq
//  Description : Self-checking bench for gray_binary_seq (N=4 and N=8).
//                A transaction-level model predicts handshake state and the
//                decoded word. Directed scenarios pin literal values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gray_binary_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   gray_binary_seq_if #(.N(4)) bus4 ();
   gray_binary_seq_if #(.N(8)) bus8 ();

   gray_binary_seq #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
   gray_binary_seq #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

   int checks = 0;
   int errors = 0;

   // Binary bit i is the XOR of all Gray bits at position i and above
   function automatic logic [7:0] g2b(input logic [7:0] g);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- transaction-level model of the N=4 instance ----------
   int         m_cnt;        // edges left until the result is ready
   logic       m_ov;
   logic [3:0] m_res;
   logic [3:0] m_prev;
   logic       m_seen;
   logic       m_err;
   logic [7:0] m_tmp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= 0;
         m_ov   <= 1'b0;
         m_res  <= 4'h0;
         m_prev <= 4'h0;
         m_seen <= 1'b0;
         m_err  <= 1'b0;
      end else if (m_ov) begin
         if (bus4.out_ready) m_ov <= 1'b0;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) m_ov <= 1'b1;
      end else if (bus4.in_valid) begin
         m_cnt  <= 3;
         m_res  <= 4'(g2b({4'h0, bus4.gray}));
         m_err  <= m_seen && ($countones(bus4.gray ^ m_prev) > 1);
         m_prev <= bus4.gray;
         m_seen <= 1'b1;
      end
   end

   // Compare process: every cycle out of reset
   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready", 8'(bus4.in_ready), 8'(!m_ov && (m_cnt == 0)));
         check("out_valid", 8'(bus4.out_valid), 8'(m_ov));
         if (m_ov) begin
            check("bin", 8'(bus4.bin), 8'(m_res));
`ifdef GRAY_BINARY_STEP_CHECK_EN
            check("step_err", 8'(bus4.step_err), 8'(m_err));
`endif
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   logic [3:0] seq  [5];
   logic       sexp [5];
   logic [3:0] rg;

   initial begin
      rst_n          = 1'b0;
      bus4.in_valid  = 1'b0; bus4.gray = '0; bus4.out_ready = 1'b0;
      bus8.in_valid  = 1'b0; bus8.gray = '0; bus8.out_ready = 1'b0;
      m_tmp          = 8'h0;
      step(3);

      // Reset state
      check("rst_in_ready", 8'(bus4.in_ready), 8'h1);
      check("rst_out_valid", 8'(bus4.out_valid), 8'h0);
      check("rst_bin", 8'(bus4.bin), 8'h0);
      check("rst8_in_ready", 8'(bus8.in_ready), 8'h1);
      check("rst8_bin", bus8.bin, 8'h00);
      rst_n = 1'b1;
      step(1);

      // Basic decode: 0110 -> 0100, valid 3 edges after acceptance
      bus4.in_valid = 1'b1; bus4.gray = 4'b0110;
      step(1);
      bus4.in_valid = 1'b0; bus4.gray = 4'b1111;
      for (int k = 1; k <= 3; k++) begin
         check("basic_in_ready", 8'(bus4.in_ready), 8'h0);
         step(1);
         check("basic_out_valid", 8'(bus4.out_valid), 8'(k == 3));
      end
      check("basic_bin", 8'(bus4.bin), 8'h04);
      check("basic_in_ready_done", 8'(bus4.in_ready), 8'h0);
      // Handshake edge with in_valid high: that word must not be taken
      bus4.out_ready = 1'b1; bus4.in_valid = 1'b1; bus4.gray = 4'b0011;
      step(1);
      check("hs_out_valid", 8'(bus4.out_valid), 8'h0);
      check("hs_in_ready", 8'(bus4.in_ready), 8'h1);
      bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
      step(1);

      // Backpressure: 1011 -> 1101 held for 10 cycles
      bus4.in_valid = 1'b1; bus4.gray = 4'b1011;
      step(1);
      bus4.in_valid = 1'b0;
      step(3);
      check("bp_out_valid", 8'(bus4.out_valid), 8'h1);
      check("bp_bin", 8'(bus4.bin), 8'h0D);
      bus4.in_valid = 1'b1; bus4.gray = 4'b0101;
      for (int k = 0; k < 10; k++) begin
         step(1);
         check("bp_hold_valid", 8'(bus4.out_valid), 8'h1);
         check("bp_hold_bin", 8'(bus4.bin), 8'h0D);
         check("bp_hold_ready", 8'(bus4.in_ready), 8'h0);
      end
      bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
      step(1);
      bus4.out_ready = 1'b0;
      step(2);
      check("bp_not_captured", 8'(bus4.in_ready), 8'h1);

      // Exhaustive N=4 with out_ready high: accepts 5 cycles apart
      bus4.out_ready = 1'b1;
      for (int g = 0; g < 16; g++) begin
         bus4.in_valid = 1'b1; bus4.gray = 4'(g);
         step(1);
         bus4.in_valid = 1'b0;
         step(2);
         check("exh_early", 8'(bus4.out_valid), 8'h0);
         step(1);
         check("exh_valid", 8'(bus4.out_valid), 8'h1);
         m_tmp = g2b(8'(g));
         check("exh_bin", 8'(bus4.bin), {4'h0, m_tmp[3:0]});
         step(1);
         check("exh_ready", 8'(bus4.in_ready), 8'h1);
      end
      bus4.out_ready = 1'b0;

      // Reset one cycle after acceptance
      bus4.in_valid = 1'b1; bus4.gray = 4'b1001;
      step(1);
      bus4.in_valid = 1'b0;
      step(1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 8'(bus4.out_valid), 8'h0);
      check("mid_rst_in_ready", 8'(bus4.in_ready), 8'h1);
      check("mid_rst_bin", 8'(bus4.bin), 8'h0);
      step(1);
      rst_n = 1'b1;
      bus4.in_valid = 1'b1; bus4.gray = 4'b1001;
      step(1);
      bus4.in_valid = 1'b0;
      step(3);
      check("post_rst_valid", 8'(bus4.out_valid), 8'h1);
      check("post_rst_bin", 8'(bus4.bin), 8'h0E);
      bus4.out_ready = 1'b1;
      step(1);
      bus4.out_ready = 1'b0;

`ifdef GRAY_BINARY_STEP_CHECK_EN
      // Step check sequence starting from a fresh reset
      seq  = '{4'b0000, 4'b0001, 4'b0011, 4'b0110, 4'b0110};
      sexp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      bus4.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus4.in_valid = 1'b1; bus4.gray = seq[i];
         step(1);
         bus4.in_valid = 1'b0;
         step(3);
         check("step_valid", 8'(bus4.out_valid), 8'h1);
         check("step_err_seq", 8'(bus4.step_err), 8'(sexp[i]));
         step(1);
      end
      bus4.out_ready = 1'b0;
`else
      seq  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      sexp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

      // N=8: FF -> AA, valid 7 edges after acceptance
      bus8.in_valid = 1'b1; bus8.gray = 8'hFF;
      step(1);
      bus8.in_valid = 1'b0; bus8.gray = 8'h00;
      for (int k = 1; k <= 7; k++) begin
         step(1);
         check("n8_out_valid", 8'(bus8.out_valid), 8'(k == 7));
         check("n8_in_ready", 8'(bus8.in_ready), 8'h0);
      end
      check("n8_bin", bus8.bin, 8'hAA);
      bus8.out_ready = 1'b1;
      step(1);
      check("n8_release", 8'(bus8.out_valid), 8'h0);
      bus8.out_ready = 1'b0;

      // Randomized traffic. Single-bit steps are mixed in so the step check
      // sees both legal and illegal transitions.
      rg = 4'h0;
      for (int c = 0; c < 3000; c++) begin
         bus4.in_valid = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) rg = 4'($urandom);
         else if ($urandom_range(0, 3) != 0) rg = rg ^ (4'h1 << $urandom_range(0, 3));
         bus4.gray      = rg;
         bus4.out_ready = ($urandom_range(0, 9) < 6);
         step(1);
      end
      bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
      step(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
